ct_pt_add_sched: RTL and testbench
==================================

// Module: ct_pt_add_sched
// PURPOSE
//  Round-robin scheduler that shares one ct_pt_add datapath instance between NUM_REQ requesters.
//  Accepts ciphertext/plaintext operand pairs over valid/ready handshakes and drives the datapath
//  from registered operands. Waits DP_LAT cycles, captures the result and returns it tagged with
//  the requester id. Sits between the HE op dispatch logic and the ct_pt_add instance.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  ID_W     2  requester id width; equals $clog2(NUM_REQ)
//  DP_LAT   1  cycles from dp_ct/dp_pt stable to dp_res valid (>=1; covers a pipelined mod_vector)
// PORTS
//  clk        in   1           clock, all state on posedge
//  reset      in   1           synchronous, active-high
//  req_valid  in   NUM_REQ     per-requester operand valid
//  req_ready  out  NUM_REQ     per-requester accept; one-hot or zero
//  req_ct     in   NUM_REQ*CT_t  per-requester input ciphertext
//  req_pt     in   NUM_REQ*PT_t  per-requester plaintext gamma
//  dp_ct      out  CT_t        registered ciphertext to ct_pt_add.in_ct
//  dp_pt      out  PT_t        registered plaintext to ct_pt_add.in_gamma
//  dp_res     in   CT_t        ct_pt_add.out_ct
//  res_valid  out  1           result available
//  res_ready  in   1           consumer accepts result
//  res_ct     out  CT_t        captured result ciphertext
//  res_id     out  ID_W        requester index owning res_ct
//  busy       out  1           state != IDLE
//  op_count   out  32          completed (handed-off) operations, wraps at 2^32
// BEHAVIOUR
//  - Reset values: state=IDLE, dp_ct/dp_pt/res_ct='0, res_id=0, res_valid=0, busy=0, op_count=0.
//    The rr pointer is set so requester 0 has top priority.
//  - FSM IDLE -> EXEC -> DONE -> IDLE.
//  - IDLE: g is the first valid requester scanning from (last_grant+1) mod NUM_REQ.
//    req_ready[g]=1 combinationally; all other req_ready bits are 0. No valid -> req_ready=0.
//    The transfer takes effect that cycle. On the clock edge: dp_ct<=req_ct[g], dp_pt<=req_pt[g],
//    res_id<=g, last_grant<=g, cnt<=DP_LAT-1, ->EXEC.
//  - EXEC: dp_ct/dp_pt held stable; req_ready=0. When cnt==0: res_ct<=dp_res, ->DONE.
//    Otherwise cnt--. EXEC lasts exactly DP_LAT cycles.
//  - DONE: res_valid=1; res_ct/res_id held stable until accepted.
//    res_valid&&res_ready -> op_count++, ->IDLE. No new grant is issued in the same cycle.
//  - Throughput: one op per DP_LAT+2 cycles with res_ready tied high.
//    Latency from req accept to res_valid is DP_LAT+1 cycles.
//  - Requesters must hold req_ct/req_pt stable while req_valid && !req_ready. The scheduler does
//    not check this. A requester that drops valid before grant is skipped, not penalised.
//  - Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
//  - A simultaneous req_valid on all requesters is handled by pure rr order; no fixed priority
//    after the first grant.
//  - No arithmetic here; operand widths pass through unchanged. All modular reduction is in
//    the datapath.
//  - reset in any state wins over all other events. An in-flight op is discarded with no res_valid.
//    The rr pointer and op_count are cleared.
//  - res_ready asserted outside DONE is ignored. req_valid during EXEC/DONE is not accepted.
// TESTING
//  1. Reset, then only req_valid[1] with ct.B[i]=5, gamma[i]=1, DP_LAT=1 ->
//     req_ready[1]=1 for 1 cycle; res_valid 2 cycles later with B=(5+DELTA) mod q, A unchanged,
//     res_id=1.
//  2. req_valid=4'b0101 held constantly, res_ready=1 -> grants in order 0,2,0,2.
//     op_count increments by 1 per DONE.
//  3. All 4 valid for 8 ops -> grant order 0,1,2,3,0,1,2,3; each res_id matches its grant.
//     Results equal the golden ct_pt_add model.
//  4. res_ready=0 for 10 cycles in DONE -> res_valid and res_ct stable.
//     req_ready=0 throughout; op_count unchanged until res_ready rises.
//  5. Assert reset in cycle 1 of EXEC with DP_LAT=3 -> no res_valid afterwards.
//     Outputs return to reset values; the next grant goes to requester 0.
//  6. DP_LAT=3 -> res_valid exactly 4 cycles after the accept cycle.
//     dp_ct/dp_pt constant across all EXEC cycles.

Source files
------------

// File: rtl/ct_pt_add_sched_if.sv
// rtl/ct_pt_add_sched_if.sv - requester, datapath and result signals of the ct_pt_add scheduler
interface ct_pt_add_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CT_W    = 64,
    parameter int PT_W    = 32
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0][CT_W-1:0] req_ct;
    logic [NUM_REQ-1:0][PT_W-1:0] req_pt;
    logic [CT_W-1:0]              dp_ct;
    logic [PT_W-1:0]              dp_pt;
    logic [CT_W-1:0]              dp_res;
    logic                         res_valid;
    logic                         res_ready;
    logic [CT_W-1:0]              res_ct;
    logic [ID_W-1:0]              res_id;

    modport slave (
        input  req_valid, req_ct, req_pt, dp_res, res_ready,
        output req_ready, dp_ct, dp_pt, res_valid, res_ct, res_id
    );

    modport master (
        output req_valid, req_ct, req_pt, dp_res, res_ready,
        input  req_ready, dp_ct, dp_pt, res_valid, res_ct, res_id
    );
endinterface

// File: rtl/ct_pt_add_sched.sv
// rtl/ct_pt_add_sched.sv - round-robin scheduler sharing one ct_pt_add datapath among requesters
module ct_pt_add_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DP_LAT  = 1,
    parameter int CT_W    = 64,
    parameter int PT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    ct_pt_add_sched_if.slave    bus,
    output logic                busy,
    output logic [31:0]         op_count
);
    localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant;
    logic             grant_found;
    logic [CNT_W-1:0] cnt;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        return ID_W'((int'(base) + 1 + k) % NUM_REQ);
    endfunction

    // First valid requester after the previous winner; the scan wraps modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && bus.req_valid[rr_idx(last_grant, k)]) begin
                grant_found = 1'b1;
                grant       = rr_idx(last_grant, k);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_found) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= ID_W'(NUM_REQ - 1);
            cnt           <= '0;
            bus.dp_ct     <= '0;
            bus.dp_pt     <= '0;
            bus.res_ct    <= '0;
            bus.res_id    <= '0;
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
            op_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.dp_ct  <= bus.req_ct[grant];
                        bus.dp_pt  <= bus.req_pt[grant];
                        bus.res_id <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_W'(DP_LAT - 1);
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        bus.res_ct    <= bus.dp_res;
                        bus.res_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE first keeps the grant out of the hand-off cycle.
                    if (bus.res_ready) begin
                        op_count      <= op_count + 32'd1;
                        bus.res_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ct_pt_add_sched.sv
// tb/tb_ct_pt_add_sched.sv - self-checking bench for ct_pt_add_sched at DP_LAT 1 and 3
module tb_ct_pt_add_sched;
    localparam int NR    = 4;
    localparam int IDW   = 2;
    localparam int CTW   = 64;
    localparam int PTW   = 32;
    localparam int Q     = 12289;
    localparam int DELTA = 4096;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        busy1, busy3;
    logic [31:0] opc1, opc3;

    always #5 clk = ~clk;

    ct_pt_add_sched_if #(.NUM_REQ(NR), .ID_W(IDW), .CT_W(CTW), .PT_W(PTW)) if1 ();
    ct_pt_add_sched_if #(.NUM_REQ(NR), .ID_W(IDW), .CT_W(CTW), .PT_W(PTW)) if3 ();

    ct_pt_add_sched #(.NUM_REQ(NR), .ID_W(IDW), .DP_LAT(1), .CT_W(CTW), .PT_W(PTW)) u1 (
        .clk(clk), .reset(rst1), .bus(if1.slave), .busy(busy1), .op_count(opc1)
    );
    ct_pt_add_sched #(.NUM_REQ(NR), .ID_W(IDW), .DP_LAT(3), .CT_W(CTW), .PT_W(PTW)) u3 (
        .clk(clk), .reset(rst3), .bus(if3.slave), .busy(busy3), .op_count(opc3)
    );

    // Datapath model: ct = {A[1],A[0],B[1],B[0]}, B[i] <- (B[i] + DELTA*gamma[i]) mod q.
    function automatic logic [63:0] golden(input logic [63:0] ct, input logic [31:0] pt);
        logic [63:0] r;
        r = ct;
        for (int i = 0; i < 2; i++) begin
            int unsigned b, g;
            b = 32'(ct[16*i +: 16]);
            g = 32'(pt[16*i +: 16]);
            r[16*i +: 16] = 16'((b + 32'(DELTA) * g) % 32'(Q));
        end
        return r;
    endfunction

    assign if1.dp_res = golden(if1.dp_ct, if1.dp_pt);

    logic [63:0] pipe_a, pipe_b;
    always @(posedge clk) begin
        pipe_a <= golden(if3.dp_ct, if3.dp_pt);
        pipe_b <= pipe_a;
    end
    assign if3.dp_res = pipe_b;

    int n_tests = 0;
    int n_fail  = 0;
    int m_last;
    int m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference round-robin rule: first valid index after the last winner.
    function automatic int model_grant(input int last, input logic [3:0] mask);
        for (int k = 1; k <= NR; k++) begin
            if (mask[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic randomize1();
        for (int i = 0; i < NR; i++) begin
            if1.req_ct[i] = {$urandom, $urandom};
            if1.req_pt[i] = {16'($urandom_range(0, Q - 1)), 16'($urandom_range(0, Q - 1))};
        end
    endtask

    task automatic randomize3();
        for (int i = 0; i < NR; i++) begin
            if3.req_ct[i] = {$urandom, $urandom};
            if3.req_pt[i] = {16'($urandom_range(0, Q - 1)), 16'($urandom_range(0, Q - 1))};
        end
    endtask

    task automatic reset1();
        @(negedge clk);
        rst1 = 1'b1;
        if1.req_valid = '0;
        if1.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        check("rst1_res_valid", 64'(if1.res_valid), 64'd0);
        check("rst1_busy", 64'(busy1), 64'd0);
        check("rst1_op_count", 64'(opc1), 64'd0);
        check("rst1_res_ct", if1.res_ct, 64'd0);
        check("rst1_res_id", 64'(if1.res_id), 64'd0);
        check("rst1_dp_ct", if1.dp_ct, 64'd0);
        check("rst1_dp_pt", 64'(if1.dp_pt), 64'd0);
        m_last  = NR - 1;
        m_count = 0;
    endtask

    // One full operation on the DP_LAT=1 instance; entered and left on a negedge.
    task automatic op1(input logic [3:0] mask, input int exp_g, input int stall, input bit rnd);
        logic [63:0] exp_ct;
        logic [3:0]  exp_rdy;
        int          lat;
        if (rnd) randomize1();
        if1.req_valid = mask;
        if1.res_ready = (stall == 0);
        exp_rdy = 4'(1 << exp_g);
        #1;
        check("grant", 64'(if1.req_ready), 64'(exp_rdy));
        exp_ct = golden(if1.req_ct[exp_g], if1.req_pt[exp_g]);
        @(negedge clk);
        check("exec_req_ready", 64'(if1.req_ready), 64'd0);
        check("exec_busy", 64'(busy1), 64'd1);
        lat = 1;
        while (!if1.res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        check("res_id", 64'(if1.res_id), 64'(exp_g));
        check("res_ct", if1.res_ct, exp_ct);
        for (int s = 0; s < stall; s++) begin
            check("stall_res_valid", 64'(if1.res_valid), 64'd1);
            check("stall_res_ct", if1.res_ct, exp_ct);
            check("stall_op_count", 64'(opc1), 64'(m_count));
            check("stall_req_ready", 64'(if1.req_ready), 64'd0);
            @(negedge clk);
        end
        if1.res_ready = 1'b1;
        @(negedge clk);
        m_count++;
        m_last = exp_g;
        check("op_count", 64'(opc1), 64'(m_count));
        check("handoff_res_valid", 64'(if1.res_valid), 64'd0);
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] mask;
        int         grant;
        int         stall;
    } vec_t;

    vec_t vt[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] ect, exp3;
        logic [31:0] ept;
        logic [3:0]  mask;
        int          g;

        rst1 = 1'b1;
        rst3 = 1'b1;
        if1.req_valid = '0; if1.res_ready = 1'b0; if1.req_ct = '0; if1.req_pt = '0;
        if3.req_valid = '0; if3.res_ready = 1'b0; if3.req_ct = '0; if3.req_pt = '0;

        vt[0]  = '{1, 4'b0101, 0, 0};
        vt[1]  = '{0, 4'b0101, 2, 0};
        vt[2]  = '{0, 4'b0101, 0, 0};
        vt[3]  = '{0, 4'b0101, 2, 0};
        vt[4]  = '{1, 4'b1111, 0, 0};
        vt[5]  = '{0, 4'b1111, 1, 0};
        vt[6]  = '{0, 4'b1111, 2, 10};
        vt[7]  = '{0, 4'b1111, 3, 0};
        vt[8]  = '{0, 4'b1111, 0, 0};
        vt[9]  = '{0, 4'b1111, 1, 0};
        vt[10] = '{0, 4'b1111, 2, 0};
        vt[11] = '{0, 4'b1111, 3, 0};
        vt[12] = '{0, 4'b1000, 3, 0};
        vt[13] = '{0, 4'b0001, 0, 0};
        vt[14] = '{0, 4'b0110, 1, 0};
        vt[15] = '{0, 4'b0100, 2, 0};
        vt[16] = '{0, 4'b1001, 3, 0};

        // Single requester 1 with B=5, gamma=1.
        reset1();
        randomize1();
        if1.req_ct[1] = {32'hABCD1234, 16'd5, 16'd5};
        if1.req_pt[1] = {16'd1, 16'd1};
        op1(4'b0010, 1, 0, 1'b0);
        check("t1_res_ct", if1.res_ct, {32'hABCD1234, 16'd4101, 16'd4101});

        for (int i = 0; i < 17; i++) begin
            if (vt[i].rst) reset1();
            op1(vt[i].mask, vt[i].grant, vt[i].stall, 1'b1);
        end

        reset1();
        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            g = model_grant(m_last, mask);
            op1(mask, g, int'($urandom_range(0, 2)), 1'b1);
        end
        if1.req_valid = '0;

        // DP_LAT=3: operand hold and accept-to-result timing.
        @(negedge clk);
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        check("u3_rst_busy", 64'(busy3), 64'd0);
        randomize3();
        if3.req_valid = 4'b0100;
        #1;
        check("u3_grant2", 64'(if3.req_ready), 64'b0100);
        ect  = if3.req_ct[2];
        ept  = if3.req_pt[2];
        exp3 = golden(ect, ept);
        @(negedge clk);
        if3.req_valid = '0;
        if3.req_ct[2] = ~ect;
        if3.req_pt[2] = ~ept;
        for (int c = 1; c <= 3; c++) begin
            check("u3_exec_dp_ct", if3.dp_ct, ect);
            check("u3_exec_dp_pt", 64'(if3.dp_pt), 64'(ept));
            check("u3_exec_res_valid", 64'(if3.res_valid), 64'd0);
            @(negedge clk);
        end
        check("u3_res_valid", 64'(if3.res_valid), 64'd1);
        check("u3_res_ct", if3.res_ct, exp3);
        check("u3_res_id", 64'(if3.res_id), 64'd2);
        if3.res_ready = 1'b1;
        @(negedge clk);
        if3.res_ready = 1'b0;
        check("u3_op_count", 64'(opc3), 64'd1);

        // Reset during the first EXEC cycle discards the operation.
        randomize3();
        if3.req_valid = 4'b1111;
        #1;
        check("u3_grant3", 64'(if3.req_ready), 64'b1000);
        @(negedge clk);
        check("u3_busy_exec", 64'(busy3), 64'd1);
        rst3 = 1'b1;
        if3.req_valid = '0;
        @(negedge clk);
        rst3 = 1'b0;
        check("u3_rst_res_valid", 64'(if3.res_valid), 64'd0);
        check("u3_rst_busy2", 64'(busy3), 64'd0);
        check("u3_rst_op_count", 64'(opc3), 64'd0);
        check("u3_rst_res_ct", if3.res_ct, 64'd0);
        check("u3_rst_res_id", 64'(if3.res_id), 64'd0);
        check("u3_rst_dp_ct", if3.dp_ct, 64'd0);
        check("u3_rst_dp_pt", 64'(if3.dp_pt), 64'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("u3_no_res_valid", 64'(if3.res_valid), 64'd0);
        end
        if3.req_valid = 4'b1111;
        #1;
        check("u3_grant_after_rst", 64'(if3.req_ready), 64'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
